// File: rtl/pipe_pkg.sv
// Shared IF/ID pipeline types: NOP encoding, handshake register states, fetch beat layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } if_id_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus_4;
    } if_id_beat_t;

endpackage

// File: rtl/pipe_slot.sv
// One load-enabled beat register with a valid bit.
// Latency: 1 cycle from load to q/vld.
// Backpressure: none; the owner decides when to load or clear.
//
// Ports:
//   CLK, RESET : clock, asynchronous active-high reset (clears data and valid)
//   load       : capture d and mark the slot valid
//   clr        : invalidate the slot, keeping the data; wins over load
//   d          : beat to capture
//   vld, q     : slot valid bit and stored beat
module pipe_slot
    import pipe_pkg::*;
#(
    parameter type beat_t = if_id_beat_t
)(
    input  logic  CLK,
    input  logic  RESET,
    input  logic  load,
    input  logic  clr,
    input  beat_t d,
    output logic  vld,
    output beat_t q
);

    // Clearing only drops the valid bit so the last loaded PC stays visible.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (clr) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= 1'b1;
            q   <= d;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake, one-entry skid buffer, flush and stall counter.
// Latency: 1 cycle fetch-to-decode; a skidded beat appears one cycle after the first consume.
// Backpressure: IN_READY drops the cycle after a skid capture, returns the cycle after the skid drains.
//
// Ports:
//   CLK, RESET                      : clock, asynchronous active-high reset
//   IN_VALID / IN_READY             : fetch handshake
//   INSTRUCTION, PC, PC_PLUS_4      : fetch beat
//   STALL                           : decode cannot consume this cycle
//   FLUSH                           : squash held and incoming beats
//   OUT_VALID                       : output fields carry a real instruction
//   INSTRUCTION_OUT                 : instruction to decode, NOP when OUT_VALID=0
//   PC_OUT, PC_PLUS_4_OUT           : last loaded PC / PC+4
//   STALL_COUNT                     : saturating count of stalled valid cycles
module if_id_skid_reg
    import pipe_pkg::*;
#(
    parameter int              XLEN  = 32,
    parameter int              ILEN  = 32,
    parameter logic [ILEN-1:0] NOP   = RV_NOP,
    parameter int              CNT_W = 16
)(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [ILEN-1:0]  INSTRUCTION,
    input  logic [XLEN-1:0]  PC,
    input  logic [XLEN-1:0]  PC_PLUS_4,
    input  logic             STALL,
    input  logic             FLUSH,
    output logic             OUT_VALID,
    output logic [ILEN-1:0]  INSTRUCTION_OUT,
    output logic [XLEN-1:0]  PC_OUT,
    output logic [XLEN-1:0]  PC_PLUS_4_OUT,
    output logic [CNT_W-1:0] STALL_COUNT
);

    // Width-parametrised twin of if_id_beat_t.
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus_4;
    } beat_t;

    if_id_state_t state_q, state_nxt;

    beat_t in_dat, out_d, out_dat, skid_dat;
    logic  out_vld, skid_vld;
    logic  out_load, out_clr, skid_load, skid_clr;
    logic  accept, consume;
    logic [CNT_W-1:0] stall_cnt;

    assign in_dat  = {INSTRUCTION, PC, PC_PLUS_4};

    // The skid valid flop is exactly "state == SKID", so it doubles as the
    // registered ready without a separate flop.
    assign IN_READY = ~skid_vld;
    assign accept   = IN_VALID & IN_READY;
    assign consume  = out_vld & ~STALL;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= EMPTY;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        out_load  = 1'b0;
        out_clr   = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        out_d     = (state_q == SKID) ? skid_dat : in_dat;

        if (FLUSH) begin
            // Anything accepted this cycle is dropped along with both slots.
            state_nxt = EMPTY;
            out_clr   = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        out_load  = 1'b1;
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (consume && accept) begin
                        out_load  = 1'b1;
                    end else if (consume) begin
                        out_clr   = 1'b1;
                        state_nxt = EMPTY;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_nxt = SKID;
                    end
                end
                SKID: begin
                    if (consume) begin
                        out_load  = 1'b1;
                        skid_clr  = 1'b1;
                        state_nxt = FULL;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    out_clr   = 1'b1;
                    skid_clr  = 1'b1;
                end
            endcase
        end
    end

    pipe_slot #(.beat_t(beat_t)) u_out_slot (
        .CLK   (CLK),
        .RESET (RESET),
        .load  (out_load),
        .clr   (out_clr),
        .d     (out_d),
        .vld   (out_vld),
        .q     (out_dat)
    );

    pipe_slot #(.beat_t(beat_t)) u_skid_slot (
        .CLK   (CLK),
        .RESET (RESET),
        .load  (skid_load),
        .clr   (skid_clr),
        .d     (in_dat),
        .vld   (skid_vld),
        .q     (skid_dat)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_cnt <= '0;
        end else if (out_vld && STALL && !FLUSH && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign OUT_VALID       = out_vld;
    assign INSTRUCTION_OUT = out_vld ? out_dat.instr : NOP;
    assign PC_OUT          = out_dat.pc;
    assign PC_PLUS_4_OUT   = out_dat.pc_plus_4;
    assign STALL_COUNT     = stall_cnt;

endmodule

// File: tb/tb_if_id_skid_reg.sv
module tb_if_id_skid_reg;

    localparam logic [31:0] NOP_EXP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        IN_VALID = 1'b0;
    logic [31:0] INSTRUCTION = '0;
    logic [31:0] PC = '0;
    logic [31:0] PC_PLUS_4 = '0;
    logic        STALL = 1'b0;
    logic        FLUSH = 1'b0;

    logic        IN_READY, OUT_VALID;
    logic [31:0] INSTRUCTION_OUT, PC_OUT, PC_PLUS_4_OUT;
    logic [15:0] STALL_COUNT;

    logic        in_ready4, out_valid4;
    logic [31:0] instr_out4, pc_out4, pc4_out4;
    logic [3:0]  stall_count4;

    always #5 CLK = ~CLK;

    if_id_skid_reg dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .INSTRUCTION(INSTRUCTION), .PC(PC), .PC_PLUS_4(PC_PLUS_4),
        .STALL(STALL), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID),
        .INSTRUCTION_OUT(INSTRUCTION_OUT), .PC_OUT(PC_OUT),
        .PC_PLUS_4_OUT(PC_PLUS_4_OUT), .STALL_COUNT(STALL_COUNT)
    );

    if_id_skid_reg #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(in_ready4),
        .INSTRUCTION(INSTRUCTION), .PC(PC), .PC_PLUS_4(PC_PLUS_4),
        .STALL(STALL), .FLUSH(FLUSH), .OUT_VALID(out_valid4),
        .INSTRUCTION_OUT(instr_out4), .PC_OUT(pc_out4),
        .PC_PLUS_4_OUT(pc4_out4), .STALL_COUNT(stall_count4)
    );

    // Reference model: the register is a FIFO of at most two beats whose head
    // is what decode sees; ready means "fewer than two beats held".
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } mbeat_t;

    mbeat_t      mq[$];
    bit          m_rdy;
    logic [31:0] m_pc, m_pc4;
    int          m_cnt16, m_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void model_reset();
        mq.delete();
        m_rdy   = 1'b1;
        m_pc    = '0;
        m_pc4   = '0;
        m_cnt16 = 0;
        m_cnt4  = 0;
    endfunction

    function automatic logic [31:0] exp_instr();
        return (mq.size() > 0) ? mq[0].instr : NOP_EXP;
    endfunction

    task automatic drive(input bit v, input logic [31:0] pc, input bit st, input bit fl);
        IN_VALID    = v;
        PC          = pc;
        PC_PLUS_4   = pc + 32'd4;
        INSTRUCTION = $urandom;
        STALL       = st;
        FLUSH       = fl;
    endtask

    // Advance the model with the current inputs, then let the DUT take the edge.
    task automatic tick();
        bit     ov, acc, cons;
        mbeat_t b;
        b    = {INSTRUCTION, PC, PC_PLUS_4};
        ov   = (mq.size() > 0);
        acc  = IN_VALID && m_rdy;
        cons = ov && !STALL;
        if (ov && STALL && !FLUSH) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15)     m_cnt4++;
        end
        if (FLUSH) begin
            mq.delete();
        end else begin
            if (cons) void'(mq.pop_front());
            if (acc)  mq.push_back(b);
        end
        m_rdy = (mq.size() < 2);
        if (mq.size() > 0) begin
            m_pc  = mq[0].pc;
            m_pc4 = mq[0].pc4;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        RESET = 1'b1;
        #3;
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
        n_checks++; if (INSTRUCTION_OUT !== NOP_EXP) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", INSTRUCTION_OUT, NOP_EXP); end
        n_checks++; if (PC_OUT !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", PC_OUT); end
        n_checks++; if (PC_PLUS_4_OUT !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h expected 0", PC_PLUS_4_OUT); end
        n_checks++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", IN_READY); end
        n_checks++; if (STALL_COUNT !== 16'h0) begin n_fail++; $display("FAIL reset_stall_count: got %0d expected 0", STALL_COUNT); end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        logic [31:0] ins;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
            ins = INSTRUCTION;
            tick();
            n_checks++; if ({OUT_VALID, IN_READY} !== 2'b11) begin n_fail++; $display("FAIL stream_valid_ready[%0d]: got %b expected 11", i, {OUT_VALID, IN_READY}); end
            n_checks++; if ({INSTRUCTION_OUT, PC_OUT, PC_PLUS_4_OUT} !== {ins, 32'(i * 4), 32'(i * 4 + 4)}) begin
                n_fail++; $display("FAIL stream_beat[%0d]: got %h/%h/%h expected %h/%h/%h", i, INSTRUCTION_OUT, PC_OUT, PC_PLUS_4_OUT, ins, i * 4, i * 4 + 4); end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        n_checks++; if ({OUT_VALID, INSTRUCTION_OUT, PC_OUT} !== {1'b0, NOP_EXP, 32'h8}) begin
            n_fail++; $display("FAIL stream_drain: got %b/%h/%h expected 0/%h/00000008", OUT_VALID, INSTRUCTION_OUT, PC_OUT, NOP_EXP); end
    endtask

    task automatic test_skid();
        do_reset();
        drive(1'b1, 32'h4, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        tick();
        n_checks++; if ({IN_READY, OUT_VALID, PC_OUT} !== {1'b0, 1'b1, 32'h4}) begin
            n_fail++; $display("FAIL skid_capture: got rdy=%b vld=%b pc=%h expected rdy=0 vld=1 pc=00000004", IN_READY, OUT_VALID, PC_OUT); end
        drive(1'b1, 32'hC, 1'b1, 1'b0);
        tick();
        tick();
        n_checks++; if ({IN_READY, PC_OUT} !== {1'b0, 32'h4}) begin
            n_fail++; $display("FAIL skid_hold: got rdy=%b pc=%h expected rdy=0 pc=00000004", IN_READY, PC_OUT); end
        n_checks++; if (STALL_COUNT !== 16'd3) begin n_fail++; $display("FAIL skid_stall_count: got %0d expected 3", STALL_COUNT); end
        STALL = 1'b0;
        tick();
        n_checks++; if ({OUT_VALID, PC_OUT, IN_READY, INSTRUCTION_OUT} !== {1'b1, 32'h8, 1'b1, exp_instr()}) begin
            n_fail++; $display("FAIL skid_drain_first: got vld=%b pc=%h rdy=%b ins=%h expected vld=1 pc=00000008 rdy=1 ins=%h", OUT_VALID, PC_OUT, IN_READY, INSTRUCTION_OUT, exp_instr()); end
        tick();
        n_checks++; if ({OUT_VALID, PC_OUT, PC_PLUS_4_OUT} !== {1'b1, 32'hC, 32'h10}) begin
            n_fail++; $display("FAIL skid_drain_second: got vld=%b pc=%h pc4=%h expected vld=1 pc=0000000c pc4=00000010", OUT_VALID, PC_OUT, PC_PLUS_4_OUT); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h14, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h18, 1'b0, 1'b1);
        tick();
        n_checks++; if ({OUT_VALID, INSTRUCTION_OUT, IN_READY, PC_OUT} !== {1'b0, NOP_EXP, 1'b1, 32'h10}) begin
            n_fail++; $display("FAIL flush_skid: got vld=%b ins=%h rdy=%b pc=%h expected vld=0 ins=%h rdy=1 pc=00000010", OUT_VALID, INSTRUCTION_OUT, IN_READY, PC_OUT, NOP_EXP); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if ({OUT_VALID, PC_OUT} !== {1'b0, 32'h10}) begin
                n_fail++; $display("FAIL flush_no_ghost[%0d]: got vld=%b pc=%h expected vld=0 pc=00000010", i, OUT_VALID, PC_OUT); end
        end
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        tick();
        n_checks++; if ({OUT_VALID, PC_OUT} !== {1'b1, 32'h40}) begin
            n_fail++; $display("FAIL flush_restart: got vld=%b pc=%h expected vld=1 pc=00000040", OUT_VALID, PC_OUT); end
    endtask

    task automatic test_stall_flush();
        do_reset();
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h24, 1'b1, 1'b1);
        tick();
        n_checks++; if (STALL_COUNT !== 16'd1) begin n_fail++; $display("FAIL stall_flush_count: got %0d expected 1", STALL_COUNT); end
        n_checks++; if ({OUT_VALID, INSTRUCTION_OUT, IN_READY, PC_OUT} !== {1'b0, NOP_EXP, 1'b1, 32'h20}) begin
            n_fail++; $display("FAIL stall_flush_out: got vld=%b ins=%h rdy=%b pc=%h expected vld=0 ins=%h rdy=1 pc=00000020", OUT_VALID, INSTRUCTION_OUT, IN_READY, PC_OUT, NOP_EXP); end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b1, 32'h30, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) begin
                n_checks++; if (stall_count4 !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got %0d expected 15", stall_count4); end
            end
        end
        n_checks++; if (stall_count4 !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d expected 15", stall_count4); end
        n_checks++; if (STALL_COUNT !== 16'd20) begin n_fail++; $display("FAIL sat_wide_count: got %0d expected 20", STALL_COUNT); end
        n_checks++; if ({OUT_VALID, PC_OUT} !== {1'b1, 32'h30}) begin
            n_fail++; $display("FAIL sat_out_hold: got vld=%b pc=%h expected vld=1 pc=00000030", OUT_VALID, PC_OUT); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 32'h50, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h54, 1'b1, 1'b0);
        tick();
        #2;
        RESET = 1'b1;
        #1;
        n_checks++; if ({OUT_VALID, INSTRUCTION_OUT, PC_OUT, PC_PLUS_4_OUT, IN_READY} !== {1'b0, NOP_EXP, 32'h0, 32'h0, 1'b1}) begin
            n_fail++; $display("FAIL async_reset_out: got vld=%b ins=%h pc=%h pc4=%h rdy=%b expected vld=0 ins=%h pc=0 pc4=0 rdy=1", OUT_VALID, INSTRUCTION_OUT, PC_OUT, PC_PLUS_4_OUT, IN_READY, NOP_EXP); end
        n_checks++; if ({STALL_COUNT, stall_count4} !== 20'h0) begin
            n_fail++; $display("FAIL async_reset_count: got %0d/%0d expected 0/0", STALL_COUNT, stall_count4); end
        #1;
        RESET = 1'b0;
        model_reset();
        drive(1'b1, 32'h60, 1'b0, 1'b0);
        tick();
        n_checks++; if ({OUT_VALID, PC_OUT, INSTRUCTION_OUT} !== {1'b1, 32'h60, exp_instr()}) begin
            n_fail++; $display("FAIL async_reset_resume: got vld=%b pc=%h ins=%h expected vld=1 pc=00000060 ins=%h", OUT_VALID, PC_OUT, INSTRUCTION_OUT, exp_instr()); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
            tick();
            n_checks++;
            if ({OUT_VALID, IN_READY, INSTRUCTION_OUT, PC_OUT, PC_PLUS_4_OUT} !==
                {mq.size() > 0, m_rdy, exp_instr(), m_pc, m_pc4}) begin
                n_fail++;
                $display("FAIL random_out[%0d]: got vld=%b rdy=%b ins=%h pc=%h pc4=%h expected vld=%b rdy=%b ins=%h pc=%h pc4=%h",
                         i, OUT_VALID, IN_READY, INSTRUCTION_OUT, PC_OUT, PC_PLUS_4_OUT,
                         mq.size() > 0, m_rdy, exp_instr(), m_pc, m_pc4);
            end
            n_checks++;
            if ({out_valid4, in_ready4, instr_out4, pc_out4, pc4_out4, stall_count4, STALL_COUNT} !==
                {mq.size() > 0, m_rdy, exp_instr(), m_pc, m_pc4, 4'(m_cnt4), 16'(m_cnt16)}) begin
                n_fail++;
                $display("FAIL random_cnt[%0d]: got vld4=%b rdy4=%b pc4=%h cnt4=%0d cnt16=%0d expected vld=%b rdy=%b pc=%h cnt4=%0d cnt16=%0d",
                         i, out_valid4, in_ready4, pc_out4, stall_count4, STALL_COUNT,
                         mq.size() > 0, m_rdy, m_pc, m_cnt4, m_cnt16);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_stall_flush();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_skid_reg.md
# if_id_skid_reg

Parametrised IF/ID pipeline register. It sits between instruction fetch and decode in the RV32IM pipeline and replaces the plain hold-on-bubble register with a valid/ready handshake and a one-entry skid buffer. When decode stalls, the fetch beat already in flight is kept instead of lost. It also supports branch/jump flush with NOP injection and a saturating stall-cycle counter for performance analysis.

## Interface
Parameters:
- XLEN, 32, width of PC and PC_PLUS_4 fields
- ILEN, 32, instruction width
- NOP, 32'h0000_0013, instruction driven when output is invalid (addi x0,x0,0)
- CNT_W, 16, stall counter width

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  asynchronous, active-high reset
- IN_VALID  in  1  fetch presents a beat
- IN_READY  out  1  register can accept a beat this cycle
- INSTRUCTION  in  ILEN  fetched instruction
- PC  in  XLEN  fetch PC
- PC_PLUS_4  in  XLEN  fetch PC+4
- STALL  in  1  decode/hazard unit cannot consume this cycle
- FLUSH  in  1  squash all held and incoming beats (taken branch/jump)
- OUT_VALID  out  1  INSTRUCTION_OUT/PC_OUT/PC_PLUS_4_OUT carry a real instruction
- INSTRUCTION_OUT  out  ILEN  instruction to decode; NOP when OUT_VALID=0
- PC_OUT  out  XLEN  PC to decode
- PC_PLUS_4_OUT  out  XLEN  PC+4 to decode
- STALL_COUNT  out  CNT_W  saturating count of stalled valid cycles

## Operation
- Storage: output slot (drives the outputs) and skid slot (ILEN+2*XLEN bits each).
- Definitions:
  - accept = IN_VALID & IN_READY.
  - consume = OUT_VALID & ~STALL.
- IN_READY is a registered signal and equals (state != SKID).
- States:
  - EMPTY: output slot invalid, skid slot invalid.
  - FULL: output slot valid, skid slot invalid.
  - SKID: output slot valid, skid slot valid.
- Transitions without FLUSH:
  - EMPTY: accept -> load output slot, go to FULL (regardless of STALL). Otherwise stay in EMPTY.
  - FULL, consume & accept: load output slot, stay in FULL.
  - FULL, consume & ~accept: go to EMPTY.
  - FULL, ~consume & accept: capture into skid slot, go to SKID.
  - FULL, ~consume & ~accept: hold.
  - SKID: consume -> move skid slot into output slot, go to FULL. Otherwise hold. No accept is possible in SKID.
- FLUSH has priority over everything:
  - Next state is EMPTY and both slots are invalidated.
  - The beat accepted in the same cycle is discarded.
  - The next cycle has INSTRUCTION_OUT=NOP and IN_READY=1.
- Output slot invalid:
  - INSTRUCTION_OUT is forced to NOP.
  - PC_OUT and PC_PLUS_4_OUT retain their last loaded value (0 after reset).
- Ordering: beats leave in arrival order. No duplication, and no loss except on FLUSH.
- STALL_COUNT: +1 on every cycle with OUT_VALID & STALL & ~FLUSH. It saturates at 2^CNT_W-1 and clears only on RESET.

## Timing
- Latency: a beat accepted at edge N appears on the outputs after edge N (1 cycle) when the path goes through the output slot. A beat captured in the skid slot appears one cycle after the first consume.
- Throughput: 1 beat/cycle with STALL=0.
- IN_READY deasserts in the cycle after a skid capture and reasserts in the cycle after the skid slot drains.
- Reset values:
  - state = EMPTY
  - OUT_VALID = 0
  - INSTRUCTION_OUT = NOP
  - PC_OUT = 0
  - PC_PLUS_4_OUT = 0
  - IN_READY = 1
  - STALL_COUNT = 0
  - skid slot cleared
- RESET assertion mid-operation takes effect immediately (asynchronous) and overrides FLUSH and STALL.
- STALL and FLUSH in the same cycle: FLUSH wins.

## Structure
- Shared package pipe_pkg holds:
  - RV_NOP constant (32'h0000_0013)
  - IF/ID state enum {EMPTY, FULL, SKID}
  - packed if_id_beat_t struct {instr, pc, pc_plus_4}
- Natural sub-module: pipe_slot. It is one load-enabled, asynchronously reset register of if_id_beat_t with a valid bit. It is instantiated twice, once for the output slot and once for the skid slot.

## Test plan
- Reset, then stream PC=0x0,0x4,0x8 with STALL=0 -> outputs follow one cycle later, OUT_VALID=1 each cycle, IN_READY stays 1.
- Output holds PC=0x4. Assert STALL for 3 cycles while IN_VALID=1 with PC=0x8 -> 0x8 captured in skid, IN_READY=0 from the next cycle, outputs hold 0x4, STALL_COUNT=3. Release STALL -> 0x8 then 0xC in order.
- State SKID (out=0x10, skid=0x14). Assert FLUSH with IN_VALID=1, PC=0x18 -> next cycle OUT_VALID=0, INSTRUCTION_OUT=0x00000013, IN_READY=1, PC_OUT=0x10. 0x14 and 0x18 never appear.
- STALL=1 and FLUSH=1 in the same cycle -> flush behaviour as above, STALL_COUNT unchanged.
- CNT_W=4: hold STALL with a valid output for 20 cycles -> STALL_COUNT=15 and stays there.
- Assert RESET asynchronously mid-cycle in SKID -> all outputs take reset values before the next CLK edge. The first beat after release appears normally.
